// File: rtl/bp_me_stream_to_lite_buffered.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_stream_to_lite_buffered
// Purpose  : Assembles a BP stream (header + N beats) into whole lite messages
//            and queues them in a small in-order message buffer.
//            Header layout (LSB first): msg_type[3:0], addr[PADDR_WIDTH-1:0],
//            size[2:0], payload[PAYLOAD_WIDTH-1:0].
// Revision : 1.0
// ============================================================================
module bp_me_stream_to_lite_buffered #(
    parameter int IN_DATA_WIDTH  = 64,
    parameter int OUT_DATA_WIDTH = 512,
    parameter int MASTER         = 0,
    parameter int BUFFER_ELS     = 2,
    parameter int PADDR_WIDTH    = 40,
    parameter int PAYLOAD_WIDTH  = 16,
    localparam int HDR_WIDTH     = 4 + PADDR_WIDTH + 3 + PAYLOAD_WIDTH,
    localparam int MSG_WIDTH     = HDR_WIDTH + OUT_DATA_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [HDR_WIDTH-1:0]      mem_header_i,
    input  logic [IN_DATA_WIDTH-1:0]  mem_data_i,
    input  logic                      mem_v_i,
    output logic                      mem_ready_o,
    input  logic                      mem_lock_i,
    output logic [MSG_WIDTH-1:0]      mem_o,
    output logic                      mem_v_o,
    input  logic                      mem_yumi_i
);

    localparam int c_IN_BYTES    = IN_DATA_WIDTH / 8;
    localparam int c_WORDS       = OUT_DATA_WIDTH / IN_DATA_WIDTH;
    localparam int c_LG_IN_BYTES = $clog2(c_IN_BYTES);
    localparam int c_LG_WORDS    = $clog2(c_WORDS);
    localparam int c_IDX_W       = (c_LG_WORDS > 0) ? c_LG_WORDS : 1;
    localparam int c_PTR_W       = (BUFFER_ELS > 1) ? $clog2(BUFFER_ELS) : 1;
    localparam int c_CNT_W       = $clog2(BUFFER_ELS + 1);
    localparam int c_SIZE_LSB    = 4 + PADDR_WIDTH;

    localparam logic [3:0] c_MSG_WR    = 4'd1;
    localparam logic [3:0] c_MSG_UC_WR = 4'd3;

    localparam logic [0:0] c_E_READY   = 1'b0;
    localparam logic [0:0] c_E_COLLECT = 1'b1;

    // Assembly side
    logic [0:0]               r_state;
    logic [c_IDX_W-1:0]       r_cnt;
    logic [c_IDX_W-1:0]       r_last;
    logic [HDR_WIDTH-1:0]     r_hdr;
    logic [IN_DATA_WIDTH-1:0] r_words [c_WORDS];

    // Message buffer
    logic [HDR_WIDTH-1:0]      r_fifo_hdr  [BUFFER_ELS];
    logic [OUT_DATA_WIDTH-1:0] r_fifo_data [BUFFER_ELS];
    logic [c_PTR_W-1:0]        r_wptr;
    logic [c_PTR_W-1:0]        r_rptr;
    logic [c_CNT_W-1:0]        r_count;
    logic                      r_ready;

    logic [3:0]                w_type;
    logic [2:0]                w_size;
    logic                      w_is_wr;
    logic                      w_data_bearing;
    logic [2:0]                w_lg_beats;
    logic                      w_clamp;
    logic [c_IDX_W-1:0]        w_first_last;
    logic [c_IDX_W-1:0]        w_slot;
    logic [c_IDX_W-1:0]        w_last;
    logic [IN_DATA_WIDTH-1:0]  w_asm [c_WORDS];
    logic [OUT_DATA_WIDTH-1:0] w_enq_data;
    logic [HDR_WIDTH-1:0]      w_enq_hdr;
    logic                      w_accept;
    logic                      w_enq;
    logic                      w_deq;
    logic                      w_v;
    logic [c_CNT_W-1:0]        w_count_next;
    logic                      w_unused;

    assign w_unused = mem_lock_i;

    // Beat count of the incoming message, as log2 so it is always a power of two
    always_comb begin
        w_type         = mem_header_i[3:0];
        w_size         = mem_header_i[c_SIZE_LSB +: 3];
        w_is_wr        = (w_type == c_MSG_WR) || (w_type == c_MSG_UC_WR);
        w_data_bearing = w_is_wr ^ (MASTER != 0);
        w_lg_beats     = 3'd0;
        w_clamp        = 1'b0;
        if (w_data_bearing && (int'(w_size) > c_LG_IN_BYTES)) begin
            if (int'(w_size) - c_LG_IN_BYTES > c_LG_WORDS) begin
                w_lg_beats = 3'(c_LG_WORDS);
                w_clamp    = 1'b1;
            end else begin
                w_lg_beats = 3'(int'(w_size) - c_LG_IN_BYTES);
            end
        end
        w_first_last = ~({c_IDX_W{1'b1}} << w_lg_beats);
    end

    // Merge the in-flight beat so the final beat can be enqueued the cycle it arrives;
    // replicating word (i mod beats) fills short messages across the full width.
    always_comb begin
        w_slot     = (r_state == c_E_READY) ? '0 : r_cnt;
        w_last     = (r_state == c_E_READY) ? w_first_last : r_last;
        w_enq_hdr  = (r_state == c_E_READY) ? mem_header_i : r_hdr;
        w_enq_data = '0;
        for (int i = 0; i < c_WORDS; i++) begin
            w_asm[i] = (w_slot == c_IDX_W'(i)) ? mem_data_i : r_words[i];
        end
        for (int i = 0; i < c_WORDS; i++) begin
            w_enq_data[i*IN_DATA_WIDTH +: IN_DATA_WIDTH] = w_asm[c_IDX_W'(i) & w_last];
        end
    end

    assign w_accept = mem_v_i & r_ready;
    assign w_enq    = w_accept & (w_slot == w_last);
    assign w_v      = (r_count != '0);
    assign w_deq    = mem_yumi_i & w_v;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_E_READY;
            r_cnt   <= '0;
            r_last  <= '0;
            r_hdr   <= '0;
        end else if (w_accept) begin
            if (r_state == c_E_READY) begin
                r_hdr  <= mem_header_i;
                r_last <= w_first_last;
            end
            if (w_enq) begin
                r_state <= c_E_READY;
                r_cnt   <= '0;
            end else begin
                r_state <= c_E_COLLECT;
                r_cnt   <= w_slot + c_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_words[w_slot] <= mem_data_i;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_enq && !w_deq) begin
            w_count_next = r_count + c_CNT_W'(1);
        end else if (!w_enq && w_deq) begin
            w_count_next = r_count - c_CNT_W'(1);
        end
    end

    // Ready is purely registered: it looks ahead at next cycle's occupancy
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_ready <= (w_count_next != c_CNT_W'(BUFFER_ELS));
            if (w_enq) begin
                r_wptr <= (r_wptr == c_PTR_W'(BUFFER_ELS - 1)) ? '0 : r_wptr + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_rptr <= (r_rptr == c_PTR_W'(BUFFER_ELS - 1)) ? '0 : r_rptr + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_fifo_hdr[r_wptr]  <= w_enq_hdr;
            r_fifo_data[r_wptr] <= w_enq_data;
        end
    end

    assign mem_ready_o = r_ready;
    assign mem_v_o     = w_v;
    assign mem_o       = {r_fifo_hdr[r_rptr], r_fifo_data[r_rptr]};

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (mem_yumi_i && !w_v) begin
                $error("bp_me_stream_to_lite_buffered: yumi without valid");
            end
            if (w_accept && (r_state == c_E_READY) && w_clamp) begin
                $error("bp_me_stream_to_lite_buffered: size %0d clamped to out width", w_size);
            end
        end
    end

    if (IN_DATA_WIDTH >= OUT_DATA_WIDTH) begin : g_width_check
        always_ff @(posedge clk_i) begin
            if (!reset_i) begin
                $error("bp_me_stream_to_lite_buffered: in width must be below out width");
            end
        end
    end
`endif

endmodule
`default_nettype wire
